// File: rtl/rng_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the random-number arbiter.
package rng_pkg;

   localparam int          LFSR_W       = 16;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

   typedef enum logic [0:0] {
      WARM  = 1'b0,
      SERVE = 1'b1
   } rng_state_e;

   // Taps on bits 15, 13, 12 and 10, feedback shifted into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rng_lfsr_core.sv
// 16-bit Fibonacci LFSR with load (priority) and step controls; a zero load value
// is replaced by the default seed so the state can never lock up at zero.
module rng_lfsr_core #(
   parameter logic [15:0] SEED_INIT = 16'hACE1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       load_i,
   input  logic [rng_pkg::LFSR_W-1:0] load_val_i,
   input  logic                       step_i,
   output logic [rng_pkg::LFSR_W-1:0] state_o
);
   import rng_pkg::*;

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   // Next-state selection: load, step or hold.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = (load_val_i == 16'h0000) ? SEED_INIT : load_val_i;
      end else if (step_i) begin
         state_d = lfsr_next(state_q);
      end else begin
         state_d = state_q;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SEED_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out one LFSR draw per grant to NUM_REQ requesters,
// with warm-up after reset or reseed.
module rng_arbiter #(
   parameter  int          NUM_REQ      = 4,
   parameter  int          WARMUP       = 16,
   parameter  logic [15:0] SEED_DEFAULT = rng_pkg::SEED_DEFAULT,
   localparam int          ID_W         = $clog2(NUM_REQ)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic                       seed_wr_i,
   input  logic [rng_pkg::LFSR_W-1:0] seed_data_i,
   output logic                       rnd_valid_o,
   output logic [rng_pkg::LFSR_W-1:0] rnd_data_o,
   output logic [ID_W-1:0]            rnd_id_o,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic                       busy_o
);
   import rng_pkg::*;

   localparam rng_state_e      RST_STATE = (WARMUP == 0) ? SERVE : WARM;
   localparam logic [7:0]      WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
   localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);

   rng_state_e        state_q, state_d;
   logic [7:0]        warm_cnt_q, warm_cnt_d;
   logic [NUM_REQ-1:0] pend_q, pend_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic              valid_q, valid_d;
   logic [LFSR_W-1:0] data_q, data_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic              busy_q, busy_d;

   logic [NUM_REQ-1:0] eff_s;
   logic [NUM_REQ-1:0] sel_oh_s;
   logic [ID_W-1:0]   sel_s;
   int                best_s;
   logic              take_s;
   logic [LFSR_W-1:0] lfsr_state_s;
   logic              lfsr_load_s;
   logic              lfsr_step_s;

   rng_lfsr_core #(.SEED_INIT(SEED_DEFAULT)) u_lfsr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (lfsr_load_s),
      .load_val_i (seed_data_i),
      .step_i     (lfsr_step_s),
      .state_o    (lfsr_state_s)
   );

   assign eff_s    = pend_q | req_i;
   assign sel_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;

   // Round-robin pick: set bit with the smallest distance past last_q.
   always_comb begin
      sel_s  = {ID_W{1'b0}};
      best_s = NUM_REQ;
      take_s = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         take_s = eff_s[j] && (((j + NUM_REQ - 1 - int'(last_q)) % NUM_REQ) < best_s);
         sel_s  = take_s ? ID_W'(j) : sel_s;
         best_s = take_s ? ((j + NUM_REQ - 1 - int'(last_q)) % NUM_REQ) : best_s;
      end
   end

   // FSM next state, LFSR controls and output next values; reseed overrides all.
   always_comb begin
      state_d     = state_q;
      warm_cnt_d  = warm_cnt_q;
      pend_d      = eff_s;
      last_d      = last_q;
      valid_d     = 1'b0;
      data_d      = data_q;
      id_d        = id_q;
      gnt_d       = {NUM_REQ{1'b0}};
      busy_d      = busy_q;
      lfsr_load_s = 1'b0;
      lfsr_step_s = 1'b0;
      if (seed_wr_i) begin
         lfsr_load_s = 1'b1;
         warm_cnt_d  = 8'd0;
         state_d     = RST_STATE;
         busy_d      = (WARMUP != 0);
      end else begin
         case (state_q)
            WARM: begin
               lfsr_step_s = 1'b1;
               warm_cnt_d  = warm_cnt_q + 8'd1;
               if (warm_cnt_q == WARM_LAST) begin
                  state_d = SERVE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = WARM;
                  busy_d  = 1'b1;
               end
            end
            SERVE: begin
               if (|eff_s) begin
                  valid_d     = 1'b1;
                  data_d      = lfsr_state_s;
                  id_d        = sel_s;
                  gnt_d       = sel_oh_s;
                  pend_d      = eff_s & ~sel_oh_s;
                  last_d      = sel_s;
                  lfsr_step_s = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
            default: begin
               state_d = RST_STATE;
               busy_d  = (WARMUP != 0);
            end
         endcase
      end
   end

   // Registers for FSM, bookkeeping and outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= RST_STATE;
         warm_cnt_q <= 8'd0;
         pend_q     <= {NUM_REQ{1'b0}};
         last_q     <= LAST_RST;
         valid_q    <= 1'b0;
         data_q     <= 16'h0000;
         id_q       <= {ID_W{1'b0}};
         gnt_q      <= {NUM_REQ{1'b0}};
         busy_q     <= (WARMUP != 0);
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         pend_q     <= pend_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         id_q       <= id_d;
         gnt_q      <= gnt_d;
         busy_q     <= busy_d;
      end
   end

   assign rnd_valid_o = valid_q;
   assign rnd_data_o  = data_q;
   assign rnd_id_o    = id_q;
   assign gnt_o       = gnt_q;
   assign busy_o      = busy_q;

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares one 16-bit Fibonacci LFSR between `NUM_REQ` game-logic requesters (enemy AI movement, power-up drop rolls, bomb-fuse jitter). It handles seeding and warm-up, and arbitrates round-robin between requesters. Each grant delivers the current LFSR state to one requester and advances the LFSR exactly one step, so no two requesters ever receive the same draw. It sits between the game-logic FSMs and the random source, in the system clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WARMUP`, 16: LFSR steps discarded after reset or reseed, 0..255.
- `SEED_DEFAULT`, 16'hACE1: reset seed; also replaces any zero seed.
- `clk` input, 1: system clock. One clock; reset is synchronous and active-high.
- `rst` input, 1: synchronous, active-high reset.
- `req` input, `NUM_REQ`: per-requester request pulse. Level or pulse both allowed; see merge rule.
- `seed_wr` input, 1: load `seed_data` into the LFSR, then re-warm.
- `seed_data` input, 16: new seed.
- `rnd_valid` output, 1: one-cycle strobe; `rnd_data`/`rnd_id` valid.
- `rnd_data` output, 16: random word delivered.
- `rnd_id` output, `$clog2(NUM_REQ)`: index of the served requester.
- `gnt` output, `NUM_REQ`: one-hot copy of `rnd_id`, qualified by `rnd_valid`.
- `busy` output, 1: high while warming up; requests are latched but not served.

## Operation
- LFSR: polynomial x^16+x^14+x^13+x^11+1. Step: `s <= {s[14:0], s[15]^s[13]^s[12]^s[10]}`. The state is never zero.
- Pending vector `pend[NUM_REQ]`: `eff = pend | req`. On a grant, `pend_next = eff & ~gnt_sel`; otherwise `pend_next = eff`.
- Merge rule: a req for an id already pending, or asserted in the same cycle as its own grant, merges into the same draw. At most one outstanding draw exists per id.
- FSM states:
  - WARM: step the LFSR every cycle and count. After `WARMUP` steps, go to SERVE. No grants. `busy`=1.
  - SERVE: if `eff` != 0, pick the first set bit searching from `last+1` mod `NUM_REQ`, wrapping. Register `rnd_valid`=1, `rnd_data`=current s, `rnd_id`/`gnt` for that id. Step the LFSR and set `last`=id. If `eff`=0, the LFSR holds and `rnd_valid`=0.
- The LFSR advances only in WARM or on a grant, so draws are deterministic for a given seed and request order.
- `seed_wr`, in any state, has priority over everything:
  - s <= (`seed_data`==0 ? `SEED_DEFAULT` : `seed_data`).
  - Warm counter clears and the FSM enters WARM; if `WARMUP`=0 it enters SERVE directly.
  - No grant that cycle (`rnd_valid`=0 next cycle). `pend` still accumulates and `last` is kept.
- `rst`:
  - s=`SEED_DEFAULT`, `pend`=0, `last`=`NUM_REQ-1` (so id 0 has first priority), warm count=0.
  - FSM enters WARM, or SERVE if `WARMUP`=0.
  - Outputs: `rnd_valid`=0, `rnd_data`=0, `rnd_id`=0, `gnt`=0, `busy`=(`WARMUP`!=0).
  - Reset mid-warm or mid-grant discards all pending requests.

## Timing
- Uncontended latency: `req` high in cycle t, SERVE state, no `seed_wr`: `rnd_valid` high in cycle t+1, for exactly one cycle.
- Throughput: one grant per cycle total. With k ids pending, every id is served within k cycles (fairness bound `NUM_REQ` cycles).
- `rnd_data`, `rnd_id` and `gnt` are registered. They hold their last values while `rnd_valid`=0; `gnt` returns to 0.
- `busy` is registered and falls in the first cycle the FSM is in SERVE. A request pending at that point is granted in that same cycle (output visible the next cycle).
- Warm-up duration: `WARMUP` cycles after reset release or after the `seed_wr` cycle.

## Structure
- Package `rng_pkg`: `LFSR_W`=16, tap constant, `SEED_DEFAULT`, FSM enum `{WARM, SERVE}`.
- Sub-module `rng_lfsr_core`: 16-bit state with `load`/`load_val` and `step` inputs and `state` output. `load` has priority over `step`, and zero is substituted on load.
- Top level holds the FSM, warm counter, pending vector, round-robin pointer and output registers.

## Test plan
- Reset with `WARMUP`=2; hold `req[0]` for one cycle once `busy`=0 -> `rnd_valid`, `rnd_id`=0, `rnd_data`=16'hB387. A second `req[1]` then gets 16'h670F.
- `WARMUP`=0; pulse `req`=4'b1111 in one cycle -> four consecutive grants, ids 0,1,2,3. Data is 16'hACE1, 16'h59C3, 16'hB387, 16'h670F.
- `seed_wr` with `seed_data`=0, `WARMUP`=0 -> next draw is 16'hACE1. `seed_wr` with 16'h0001 -> next draw 16'h0001, then 16'h0002.
- `req[2]` held high continuously alongside a pulsing `req[0]` -> grants alternate 0/2. No id waits more than `NUM_REQ` cycles; the held id is served once per grant cycle.
- `seed_wr` asserted in the same cycle as a pending `req[1]` -> no `rnd_valid` next cycle. `req[1]` is served after warm-up with the first post-warm value.
- `rst` asserted while three ids are pending -> all outputs at reset values, `pend` cleared, and no grants follow without new requests.
